sram_mem_ctrl: RTL

- Multi-cycle data-memory back end for the memory stage.
- Sits between the EXE/MEM pipeline signals (read enable, write enable, ALU address, store data) and an external 16-bit asynchronous SRAM.
- Each 32-bit word is moved as two 16-bit half accesses.
- Drives `ready`; the pipeline freezes all stages and pipeline registers while `ready` is low.

---
 rtl/sram_mem_ctrl_pkg.sv | 16 +
 rtl/sram_mem_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the two-half-access SRAM data-memory controller.
// Holds the state encoding, the default data-space base and the half selects.
package sram_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int   BASE_ADDR_DEFAULT = 1024;
   localparam logic HALF_LO           = 1'b0;
   localparam logic HALF_HI           = 1'b1;

endpackage

// File: rtl/sram_mem_ctrl.sv
// Memory-stage back end: moves one 32-bit word per request as two timed
// 16-bit accesses to an asynchronous SRAM and stalls the pipeline meanwhile.
module sram_mem_ctrl
   import sram_mem_ctrl_pkg::*;
#(
   parameter int BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        addr,
   input  logic [31:0]        wr_data,
   output logic [31:0]        rd_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_we_n,
   output logic               sram_oe_n
);

   localparam logic [31:0] BASE_W  = 32'(BASE_ADDR);
   localparam logic [3:0]  WAIT_M1 = 4'(WAIT_CYCLES - 1);
   localparam int          WW      = SRAM_AW - 1;

   state_t             state_r, state_s;
   logic [3:0]         cnt_r, cnt_s;
   logic [WW-1:0]      word_r, word_in_s, word_s;
   logic [31:0]        wdata_r, data_s;
   logic               write_r, write_s;
   logic [15:0]        lo_half_r;
   logic               req_s, last_s;
   logic [SRAM_AW-1:0] sram_addr_s;
   logic [15:0]        dq_out_s;
   logic               dq_oe_s, we_n_s, oe_n_s;

   assign word_in_s = WW'((addr - BASE_W) >> 2);
   assign req_s     = rd_en | wr_en;
   assign last_s    = (cnt_r == 4'd0);
   // Pin values for the first half come straight from the request being accepted
   assign word_s    = (state_r == IDLE) ? word_in_s : word_r;
   assign data_s    = (state_r == IDLE) ? wr_data   : wdata_r;
   assign write_s   = (state_r == IDLE) ? wr_en     : write_r;

   // Next state, wait counter and the stall signal
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      ready   = 1'b0;
      case (state_r)
         IDLE: begin
            ready = ~req_s;
            if (req_s) begin
               state_s = LO;
               cnt_s   = WAIT_M1;
            end else begin
               state_s = IDLE;
            end
         end
         LO: begin
            if (last_s) begin
               state_s = HI;
               cnt_s   = WAIT_M1;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         HI: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         DONE: begin
            ready   = 1'b1;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // SRAM pin values for the state being entered, registered below
   always_comb begin
      sram_addr_s = sram_addr;
      dq_out_s    = sram_dq_out;
      dq_oe_s     = 1'b0;
      we_n_s      = 1'b1;
      oe_n_s      = 1'b1;
      case (state_s)
         LO, HI: begin
            sram_addr_s = {word_s, (state_s == HI) ? HALF_HI : HALF_LO};
            if (write_s) begin
               dq_oe_s  = 1'b1;
               we_n_s   = 1'b0;
               dq_out_s = (state_s == HI) ? data_s[31:16] : data_s[15:0];
            end else begin
               oe_n_s = 1'b0;
            end
         end
         default: begin
            sram_addr_s = sram_addr;
         end
      endcase
   end

   // State, request latch, read assembly and registered SRAM pins
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r     <= IDLE;
         cnt_r       <= 4'd0;
         word_r      <= '0;
         wdata_r     <= 32'd0;
         write_r     <= 1'b0;
         lo_half_r   <= 16'd0;
         rd_data     <= 32'd0;
         sram_addr   <= '0;
         sram_dq_out <= 16'd0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         sram_addr   <= sram_addr_s;
         sram_dq_out <= dq_out_s;
         sram_dq_oe  <= dq_oe_s;
         sram_we_n   <= we_n_s;
         sram_oe_n   <= oe_n_s;
         if (state_r == IDLE && req_s) begin
            word_r  <= word_in_s;
            wdata_r <= wr_data;
            write_r <= wr_en;
         end
         if (state_r == LO && last_s && !write_r) begin
            lo_half_r <= sram_dq_in;
         end
         if (state_r == HI && last_s && !write_r) begin
            rd_data <= {sram_dq_in, lo_half_r};
         end
      end
   end

endmodule
